// File: rtl/picobello_eoc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : picobello_eoc_pkg
//  Description : Shared definitions for the end-of-computation monitor.
//                Holds the register map offsets, the FSM state encoding,
//                the exit code reported on watchdog expiry and a helper
//                that forms the exit code for a normal end of run.
//  Revision    : 1.0 - initial release
// ============================================================================
package picobello_eoc_pkg;

    // Byte offsets of the register window (bits [1:0] are ignored on decode)
    localparam logic [31:0] c_OFF_EOC      = 32'h0000_0000;
    localparam logic [31:0] c_OFF_CL_MASK  = 32'h0000_0004;
    localparam logic [31:0] c_OFF_CL_DONE  = 32'h0000_0008;
    localparam logic [31:0] c_OFF_TO_LIMIT = 32'h0000_000C;
    localparam logic [31:0] c_OFF_CYCLE_LO = 32'h0000_0010;
    localparam logic [31:0] c_OFF_CYCLE_HI = 32'h0000_0014;

    // Exit code presented when the watchdog ends the run
    localparam logic [31:0] c_TIMEOUT_EXIT_CODE = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RUN     = 3'd1,
        WAIT    = 3'd2,
        DONE    = 3'd3,
        TIMEOUT = 3'd4
    } eoc_state_e;

    // A normal exit code always has bit 31 clear so it can never alias the
    // all-ones timeout code.
    function automatic logic [31:0] normal_exit_code(input logic [30:0] code);
        return {1'b0, code};
    endfunction

endpackage
`default_nettype wire

// File: rtl/picobello_eoc_regs.sv
`default_nettype none
// ============================================================================
//  Module      : picobello_eoc_regs
//  Description : Register window of the EOC monitor: request/response
//                handshake (single outstanding transaction), address decode,
//                error generation and the host-writable CL_MASK / TO_LIMIT
//                registers. Read-only values are supplied by the parent.
//  Ports       : clk, rst                 clock, async active-high reset
//                i_req_* / o_req_ready    request channel
//                o_rsp_* / i_rsp_ready    response channel
//                i_eoc, i_code            EOC register read-back
//                i_cl_done, i_count       CL_DONE and cycle counter read-back
//                o_req_fire               any request accepted this cycle
//                o_eoc_wr, o_eoc_code     accepted EOC write with bit0 set
//                o_cl_mask, o_to_limit    register contents
//  Revision    : 1.0 - initial release
// ============================================================================
module picobello_eoc_regs
    import picobello_eoc_pkg::*;
#(
    parameter int unsigned NUM_CLUSTERS = 16,
    parameter int unsigned ADDR_WIDTH   = 5,
    parameter int unsigned CNT_WIDTH    = 48
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_req_valid,
    output logic                    o_req_ready,
    input  logic [ADDR_WIDTH-1:0]   i_req_addr,
    input  logic                    i_req_write,
    input  logic [31:0]             i_req_wdata,
    input  logic [3:0]              i_req_wstrb,
    output logic                    o_rsp_valid,
    input  logic                    i_rsp_ready,
    output logic [31:0]             o_rsp_rdata,
    output logic                    o_rsp_error,
    input  logic                    i_eoc,
    input  logic [30:0]             i_code,
    input  logic [NUM_CLUSTERS-1:0] i_cl_done,
    input  logic [CNT_WIDTH-1:0]    i_count,
    output logic                    o_req_fire,
    output logic                    o_eoc_wr,
    output logic [30:0]             o_eoc_code,
    output logic [NUM_CLUSTERS-1:0] o_cl_mask,
    output logic [CNT_WIDTH-1:0]    o_to_limit
);

    logic                    r_rsp_valid;
    logic [31:0]             r_rsp_rdata;
    logic                    r_rsp_error;
    logic [NUM_CLUSTERS-1:0] r_cl_mask;
    logic [31:0]             r_to_limit;

    logic        w_fire;
    logic [31:0] w_addr;
    logic [31:0] w_rdata;
    logic        w_error;
    logic        w_wr_eoc;
    logic        w_wr_mask;
    logic        w_wr_limit;

    // A new request may enter whenever the response slot is empty or is
    // being drained in the same cycle.
    assign o_req_ready = !r_rsp_valid || i_rsp_ready;
    assign w_fire      = i_req_valid && o_req_ready;
    assign w_addr      = 32'(i_req_addr) & 32'hFFFF_FFFC;

    always_comb begin
        w_rdata    = '0;
        w_error    = 1'b0;
        w_wr_eoc   = 1'b0;
        w_wr_mask  = 1'b0;
        w_wr_limit = 1'b0;
        if (i_req_write) begin
            // Partial writes are rejected outright, without side effects
            if (i_req_wstrb != 4'hF) begin
                w_error = 1'b1;
            end else begin
                case (w_addr)
                    c_OFF_EOC:      w_wr_eoc   = 1'b1;
                    c_OFF_CL_MASK:  w_wr_mask  = 1'b1;
                    c_OFF_TO_LIMIT: w_wr_limit = 1'b1;
                    default:        w_error    = 1'b1; // read-only or unmapped
                endcase
            end
        end else begin
            case (w_addr)
                c_OFF_EOC:      w_rdata = {i_code, i_eoc};
                c_OFF_CL_MASK:  w_rdata = 32'(r_cl_mask);
                c_OFF_CL_DONE:  w_rdata = 32'(i_cl_done);
                c_OFF_TO_LIMIT: w_rdata = r_to_limit;
                c_OFF_CYCLE_LO: w_rdata = 32'(i_count);
                c_OFF_CYCLE_HI: w_rdata = 32'(i_count >> 32);
                default:        w_error = 1'b1;
            endcase
        end
    end

    // Response slot: loaded on acceptance, held until the consumer takes it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_error <= 1'b0;
        end else if (w_fire) begin
            r_rsp_valid <= 1'b1;
            r_rsp_rdata <= w_rdata;
            r_rsp_error <= w_error;
        end else if (i_rsp_ready) begin
            r_rsp_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cl_mask  <= '0;
            r_to_limit <= '0;
        end else if (w_fire) begin
            if (w_wr_mask) begin
                r_cl_mask <= i_req_wdata[NUM_CLUSTERS-1:0];
            end
            if (w_wr_limit) begin
                r_to_limit <= i_req_wdata;
            end
        end
    end

    assign o_rsp_valid = r_rsp_valid;
    assign o_rsp_rdata = r_rsp_rdata;
    assign o_rsp_error = r_rsp_error;
    assign o_req_fire  = w_fire;
    assign o_eoc_wr    = w_fire && w_wr_eoc && i_req_wdata[0];
    assign o_eoc_code  = i_req_wdata[31:1];
    assign o_cl_mask   = r_cl_mask;
    assign o_to_limit  = CNT_WIDTH'(r_to_limit);

endmodule
`default_nettype wire

// File: rtl/picobello_eoc_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : picobello_eoc_monitor
//  Description : End-of-computation monitor. Latches the host exit code,
//                optionally waits for selected clusters to report done and
//                guards the run with a cycle watchdog. eoc_o / exit_code_o
//                form a registered, stable pair for the polling harness.
//  Ports       : clk_i, rst_i              clock, async active-high reset
//                req_* / rsp_*             register bus (see picobello_eoc_regs)
//                cluster_done_i            level done flag per cluster
//                eoc_o, exit_code_o        run finished and its exit code
//                timeout_o                 watchdog fired (sticky)
//  Revision    : 1.0 - initial release
// ============================================================================
module picobello_eoc_monitor
    import picobello_eoc_pkg::*;
#(
    parameter int unsigned NUM_CLUSTERS = 16,
    parameter int unsigned ADDR_WIDTH   = 5,
    parameter int unsigned CNT_WIDTH    = 48
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    req_valid_i,
    output logic                    req_ready_o,
    input  logic [ADDR_WIDTH-1:0]   req_addr_i,
    input  logic                    req_write_i,
    input  logic [31:0]             req_wdata_i,
    input  logic [3:0]              req_wstrb_i,
    output logic                    rsp_valid_o,
    input  logic                    rsp_ready_i,
    output logic [31:0]             rsp_rdata_o,
    output logic                    rsp_error_o,
    input  logic [NUM_CLUSTERS-1:0] cluster_done_i,
    output logic                    eoc_o,
    output logic [31:0]             exit_code_o,
    output logic                    timeout_o
);

    eoc_state_e              r_state;
    eoc_state_e              w_state_next;
    logic [CNT_WIDTH-1:0]    r_count;
    logic [NUM_CLUSTERS-1:0] r_cl_done;
    logic [30:0]             r_code;
    logic                    r_eoc;
    logic [31:0]             r_exit_code;
    logic                    r_timeout;

    logic                    w_req_fire;
    logic                    w_eoc_wr;
    logic [30:0]             w_eoc_code;
    logic [NUM_CLUSTERS-1:0] w_cl_mask;
    logic [CNT_WIDTH-1:0]    w_to_limit;
    logic                    w_active;
    logic                    w_timeout_hit;
    logic                    w_mask_met;
    logic                    w_enter_run;

    picobello_eoc_regs #(
        .NUM_CLUSTERS (NUM_CLUSTERS),
        .ADDR_WIDTH   (ADDR_WIDTH),
        .CNT_WIDTH    (CNT_WIDTH)
    ) u_regs (
        .clk         (clk_i),
        .rst         (rst_i),
        .i_req_valid (req_valid_i),
        .o_req_ready (req_ready_o),
        .i_req_addr  (req_addr_i),
        .i_req_write (req_write_i),
        .i_req_wdata (req_wdata_i),
        .i_req_wstrb (req_wstrb_i),
        .o_rsp_valid (rsp_valid_o),
        .i_rsp_ready (rsp_ready_i),
        .o_rsp_rdata (rsp_rdata_o),
        .o_rsp_error (rsp_error_o),
        .i_eoc       (r_eoc),
        .i_code      (r_code),
        .i_cl_done   (r_cl_done),
        .i_count     (r_count),
        .o_req_fire  (w_req_fire),
        .o_eoc_wr    (w_eoc_wr),
        .o_eoc_code  (w_eoc_code),
        .o_cl_mask   (w_cl_mask),
        .o_to_limit  (w_to_limit)
    );

    assign w_active      = (r_state == RUN) || (r_state == WAIT);
    // A zero limit disables the watchdog
    assign w_timeout_hit = w_active && (w_to_limit != '0) && (r_count == w_to_limit);
    // Evaluated against the live mask so a mask change while waiting takes
    // effect immediately.
    assign w_mask_met    = ((r_cl_done & w_cl_mask) == w_cl_mask);
    assign w_enter_run   = (r_state == IDLE) && w_req_fire;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_req_fire) begin
                    w_state_next = RUN;
                end
            end
            RUN: begin
                // The watchdog wins over an EOC write in the same cycle
                if (w_timeout_hit) begin
                    w_state_next = TIMEOUT;
                end else if (w_eoc_wr) begin
                    w_state_next = (w_cl_mask != '0) ? WAIT : DONE;
                end
            end
            WAIT: begin
                if (w_timeout_hit) begin
                    w_state_next = TIMEOUT;
                end else if (w_mask_met) begin
                    w_state_next = DONE;
                end
            end
            default: begin
                w_state_next = r_state; // DONE / TIMEOUT are terminal
            end
        endcase
    end

    // Cycle counter: zero while idle, saturating while running, frozen once
    // the run ends or the limit is reached.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_count <= '0;
        end else if (r_state == IDLE) begin
            r_count <= '0;
        end else if (w_active && !w_timeout_hit && (r_count != '1)) begin
            r_count <= r_count + CNT_WIDTH'(1);
        end
    end

    // Sticky per-cluster done flags, restarted when a run begins
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_cl_done <= '0;
        end else if (w_enter_run) begin
            r_cl_done <= '0;
        end else begin
            r_cl_done <= r_cl_done | (cluster_done_i & w_cl_mask);
        end
    end

    // The code is captured only by the write that actually ends the RUN
    // phase; later EOC writes are acknowledged but leave it untouched.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_code <= '0;
        end else if ((r_state == RUN) && w_eoc_wr && !w_timeout_hit) begin
            r_code <= w_eoc_code;
        end
    end

    // Outputs are loaded from the terminal state, so they switch together
    // and never change again until reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_eoc       <= 1'b0;
            r_exit_code <= '0;
            r_timeout   <= 1'b0;
        end else if (r_state == DONE) begin
            r_eoc       <= 1'b1;
            r_exit_code <= normal_exit_code(r_code);
        end else if (r_state == TIMEOUT) begin
            r_eoc       <= 1'b1;
            r_exit_code <= c_TIMEOUT_EXIT_CODE;
            r_timeout   <= 1'b1;
        end
    end

    assign eoc_o       = r_eoc;
    assign exit_code_o = r_exit_code;
    assign timeout_o   = r_timeout;

endmodule
`default_nettype wire
